// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single synchronous memory port: CPU by default,
// DMA on idle CPU, on starvation timeout, or while holding a locked burst.
module mem_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    typedef enum logic {NORM, BURST} state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;
    logic       dma_rvalid_q, dma_rvalid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= NORM;
            wait_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    // Grants are gated by reset so nothing reaches memory while reset is held.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        cpu_gnt     = 1'b0;
        dma_gnt     = 1'b0;
        if (reset) begin
            case (state_q)
                NORM: begin
                    dma_gnt = dma_req & (~cpu_req | (wait_cnt_q == MAX_WAIT_C));
                    cpu_gnt = cpu_req & ~dma_gnt;
                    if (dma_gnt && dma_lock) begin
                        state_d     = BURST;
                        burst_cnt_d = 8'd1;
                    end
                end
                BURST: begin
                    if (dma_req && dma_lock && (burst_cnt_q < MAX_BURST_C)) begin
                        dma_gnt     = 1'b1;
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end else begin
                        // Leaving a burst: CPU wins, starvation override suppressed.
                        cpu_gnt     = cpu_req;
                        dma_gnt     = dma_req & ~cpu_req;
                        state_d     = NORM;
                        burst_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = NORM;
                    burst_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dma_req || dma_gnt)
            wait_cnt_d = '0;
        else if (wait_cnt_q < MAX_WAIT_C)
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_rvalid_d = cpu_gnt & ~cpu_we;
    assign dma_rvalid_d = dma_gnt & ~dma_we;

    assign cpu_stall  = reset & cpu_req & ~cpu_gnt;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule
